// File: rtl/btn_pkg.sv
// Shared constants and small helpers for the button/switch counter controller.
package btn_pkg;

    // Request indices; lower index wins arbitration.
    localparam logic [1:0] REQ_KEY_UP = 2'd0;
    localparam logic [1:0] REQ_KEY_DN = 2'd1;
    localparam logic [1:0] REQ_SW_UP  = 2'd2;
    localparam logic [1:0] REQ_SW_DN  = 2'd3;

    localparam int NUM_REQ = 4;

    // Resting levels of the raw pins: buttons are active-low, switches active-high.
    localparam logic KEY_IDLE = 1'b1;
    localparam logic SW_IDLE  = 1'b0;

    // Isolate the lowest set bit, giving a one-hot fixed-priority grant.
    function automatic logic [3:0] lowest_set(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    // Encode a one-hot grant into its request index.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0001: idx = REQ_KEY_UP;
            4'b0010: idx = REQ_KEY_DN;
            4'b0100: idx = REQ_SW_UP;
            4'b1000: idx = REQ_SW_DN;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/button_count_ctrl_if.sv
// Board-side bundle: raw pins in, counters and event strobe out.
interface button_count_ctrl_if #(
    parameter int CNT_W = 7
);
    logic [1:0]       KEY;
    logic [1:0]       SW;
    logic [CNT_W-1:0] count_KEY;
    logic [CNT_W-1:0] count_SW;
    logic             evt_valid;
    logic [1:0]       evt_id;

    // Board / stimulus side: drives pins, observes counters.
    modport master (
        output KEY,
        output SW,
        input  count_KEY,
        input  count_SW,
        input  evt_valid,
        input  evt_id
    );

    // Controller side.
    modport slave (
        input  KEY,
        input  SW,
        output count_KEY,
        output count_SW,
        output evt_valid,
        output evt_id
    );
endinterface

// File: rtl/btn_debounce.sv
// One input bit: synchroniser, stability counter, accepted level and a
// single-cycle pulse when the accepted level leaves its idle value.
module btn_debounce #(
    parameter int   SYNC_STG  = 2,
    parameter int   DB_CYCLES = 500000,
    parameter logic IDLE      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic act_o
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STG-1:0] sync_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                stable_q, stable_d;
    logic                prev_q;
    logic                synced_s;

    assign synced_s = sync_q[SYNC_STG-1];

    // Metastability chain, preset to the idle level so reset looks like "nothing pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STG{IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], raw_i};
        end
    end

    // Accept the synced level only after it has differed for DB_CYCLES consecutive clocks.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (synced_s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = synced_s;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter, accepted level and its one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= IDLE;
            prev_q   <= IDLE;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
        end
    end

    // Only the transition away from idle is an action; returning to idle is silent.
    assign act_o = (stable_q != IDLE) && (prev_q == IDLE);

endmodule

// File: rtl/button_count_ctrl.sv
// Turns debounced KEY/SW actions into one +1/-1 step each on two counters,
// queuing simultaneous actions and servicing them one per clock by priority.
module button_count_ctrl
    import btn_pkg::*;
#(
    parameter int CNT_W     = 7,
    parameter int DB_CYCLES = 500000,
    parameter int SYNC_STG  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_count_ctrl_if.slave   bus
);
    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    logic [3:0]       req_s;
    logic [3:0]       grant_s;
    logic [1:0]       grant_idx_s;
    logic [3:0]       pend_q, pend_d;
    logic [CNT_W-1:0] count_key_q, count_key_d;
    logic [CNT_W-1:0] count_sw_q, count_sw_d;
    logic             evt_valid_q, evt_valid_d;
    logic [1:0]       evt_id_q, evt_id_d;

    // Reset asserts immediately but releases synchronously to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    btn_debounce #(.SYNC_STG(SYNC_STG), .DB_CYCLES(DB_CYCLES), .IDLE(KEY_IDLE)) u_db_key0 (
        .clk(clk), .rst_n(rst_int_n), .raw_i(bus.KEY[0]), .act_o(req_s[REQ_KEY_UP])
    );
    btn_debounce #(.SYNC_STG(SYNC_STG), .DB_CYCLES(DB_CYCLES), .IDLE(KEY_IDLE)) u_db_key1 (
        .clk(clk), .rst_n(rst_int_n), .raw_i(bus.KEY[1]), .act_o(req_s[REQ_KEY_DN])
    );
    btn_debounce #(.SYNC_STG(SYNC_STG), .DB_CYCLES(DB_CYCLES), .IDLE(SW_IDLE)) u_db_sw0 (
        .clk(clk), .rst_n(rst_int_n), .raw_i(bus.SW[0]), .act_o(req_s[REQ_SW_UP])
    );
    btn_debounce #(.SYNC_STG(SYNC_STG), .DB_CYCLES(DB_CYCLES), .IDLE(SW_IDLE)) u_db_sw1 (
        .clk(clk), .rst_n(rst_int_n), .raw_i(bus.SW[1]), .act_o(req_s[REQ_SW_DN])
    );

    assign grant_s     = lowest_set(pend_q);
    assign grant_idx_s = onehot_to_idx(grant_s);

    // Pending bookkeeping and the shared adder; a new request beats a same-cycle grant clear.
    always_comb begin
        pend_d      = (pend_q & ~grant_s) | req_s;
        count_key_d = count_key_q;
        count_sw_d  = count_sw_q;
        evt_valid_d = 1'b0;
        evt_id_d    = evt_id_q;
        if (grant_s != 4'b0000) begin
            evt_valid_d = 1'b1;
            evt_id_d    = grant_idx_s;
            case (grant_idx_s)
                REQ_KEY_UP: count_key_d = count_key_q + CNT_W'(1);
                REQ_KEY_DN: count_key_d = count_key_q - CNT_W'(1);
                REQ_SW_UP:  count_sw_d  = count_sw_q + CNT_W'(1);
                REQ_SW_DN:  count_sw_d  = count_sw_q - CNT_W'(1);
                default:    begin end
            endcase
        end else begin
            evt_valid_d = 1'b0;
        end
    end

    // State and registered outputs; reset drops any queued requests.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pend_q      <= 4'b0000;
            count_key_q <= '0;
            count_sw_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= 2'd0;
        end else begin
            pend_q      <= pend_d;
            count_key_q <= count_key_d;
            count_sw_q  <= count_sw_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
        end
    end

    assign bus.count_KEY = count_key_q;
    assign bus.count_SW  = count_sw_q;
    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_id    = evt_id_q;

endmodule
